// File: rtl/mix_sched_pkg.sv
// Shared types and helpers for the time-multiplexed IQ mixer scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mix_sched_pkg;

   // Native I/O width of the shared complex mixer.
   localparam int MIX_IO_W = 16;

   // Width of each per-channel accept counter (optional statistics build).
   localparam int STAT_W = 16;

   typedef struct packed {
      logic signed [MIX_IO_W-1:0] re;
      logic signed [MIX_IO_W-1:0] im;
   } iq_sample_t;

   typedef struct packed {
      logic signed [MIX_IO_W-1:0] cos;
      logic signed [MIX_IO_W-1:0] sin;
   } lo_sample_t;

   // Channel tag width. Never returns 0, so a lone channel still gets a 1-bit tag.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mix_rr_arbiter.sv
// Round-robin grant: picks the first requester at or after ptr_i, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: en_i low forces an all-zero grant; the caller owns the pointer.
module mix_rr_arbiter
   import mix_sched_pkg::*;
#(
   parameter  int NUM_CH = 4,
   localparam int CH_W   = ch_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   input  logic              en_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [CH_W-1:0]   gnt_idx_o,
   output logic              any_gnt_o
);

   // Channel index at offset off from p, modulo NUM_CH.
   function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] p, input int off);
      int s;
      s = int'(p) + off;
      if (s >= NUM_CH) s = s - NUM_CH;
      return CH_W'(s);
   endfunction

   // Scan NUM_CH slots starting at the pointer and take the first valid one.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      any_gnt_o = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (en_i && !any_gnt_o && req_i[wrap_idx(ptr_i, i)]) begin
            gnt_o[wrap_idx(ptr_i, i)] = 1'b1;
            gnt_idx_o                 = wrap_idx(ptr_i, i);
            any_gnt_o                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mix_sched.sv
// Round-robin scheduler sharing one combinational IQ mixer across NUM_CH channels (stats: MIX_SCHED_STATS_EN).
// Latency: 2 cycles from accept to out_valid_o; 1 result/cycle when out_ready_i is held high.
// Backpressure: out_ready_i low freezes S2, then S1, and blocks new grants; ready depends on valid.
module mix_sched
   import mix_sched_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int IO_W   = 16,
   localparam int CH_W   = ch_w(NUM_CH)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   enable_i,
   input  logic [NUM_CH-1:0]      req_valid_i,
   output logic [NUM_CH-1:0]      req_ready_o,
   input  logic [NUM_CH*IO_W-1:0] req_re_i,
   input  logic [NUM_CH*IO_W-1:0] req_im_i,
   input  logic [NUM_CH*IO_W-1:0] req_cos_i,
   input  logic [NUM_CH*IO_W-1:0] req_sin_i,
   output logic [IO_W-1:0]        mix_re_o,
   output logic [IO_W-1:0]        mix_im_o,
   output logic [IO_W-1:0]        mix_cos_o,
   output logic [IO_W-1:0]        mix_sin_o,
   input  logic [IO_W-1:0]        mix_re_i,
   input  logic [IO_W-1:0]        mix_im_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [IO_W-1:0]        out_re_o,
   output logic [IO_W-1:0]        out_im_o,
   output logic [CH_W-1:0]        out_ch_o
`ifdef MIX_SCHED_STATS_EN
   ,
   input  logic                       stat_clr_i,
   output logic [NUM_CH*STAT_W-1:0]   stat_cnt_o
`endif
);

   logic              s1_valid_q, s1_valid_d;
   logic [IO_W-1:0]   s1_re_q, s1_re_d, s1_im_q, s1_im_d;
   logic [IO_W-1:0]   s1_cos_q, s1_cos_d, s1_sin_q, s1_sin_d;
   logic [CH_W-1:0]   s1_ch_q, s1_ch_d;
   logic              s2_valid_q, s2_valid_d;
   logic [IO_W-1:0]   s2_re_q, s2_re_d, s2_im_q, s2_im_d;
   logic [CH_W-1:0]   s2_ch_q, s2_ch_d;
   logic [CH_W-1:0]   ptr_q, ptr_d;

   logic              s2_adv, s1_adv, arb_en;
   logic [NUM_CH-1:0] gnt;
   logic [CH_W-1:0]   gnt_idx;
   logic              any_gnt;

   assign s2_adv = !s2_valid_q || out_ready_i;
   assign s1_adv = !s1_valid_q || s2_adv;
   // Reset gating keeps req_ready_o low while the block is held in reset.
   assign arb_en = enable_i && s1_adv && !rst_i;

   mix_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req_i     (req_valid_i),
      .ptr_i     (ptr_q),
      .en_i      (arb_en),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_gnt_o (any_gnt)
   );

   assign req_ready_o = gnt;

   // Next-state for both pipeline stages and the round-robin pointer.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_re_d    = s1_re_q;
      s1_im_d    = s1_im_q;
      s1_cos_d   = s1_cos_q;
      s1_sin_d   = s1_sin_q;
      s1_ch_d    = s1_ch_q;
      s2_valid_d = s2_valid_q;
      s2_re_d    = s2_re_q;
      s2_im_d    = s2_im_q;
      s2_ch_d    = s2_ch_q;
      ptr_d      = ptr_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         s2_re_d    = mix_re_i;
         s2_im_d    = mix_im_i;
         s2_ch_d    = s1_ch_q;
      end
      if (s1_adv) begin
         if (any_gnt) begin
            s1_valid_d = 1'b1;
            s1_re_d    = req_re_i[gnt_idx*IO_W +: IO_W];
            s1_im_d    = req_im_i[gnt_idx*IO_W +: IO_W];
            s1_cos_d   = req_cos_i[gnt_idx*IO_W +: IO_W];
            s1_sin_d   = req_sin_i[gnt_idx*IO_W +: IO_W];
            s1_ch_d    = gnt_idx;
            ptr_d      = (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + CH_W'(1);
         end else begin
            s1_valid_d = 1'b0;
         end
      end
   end

   // Pipeline and pointer registers; reset drops anything in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_re_q    <= '0;
         s1_im_q    <= '0;
         s1_cos_q   <= '0;
         s1_sin_q   <= '0;
         s1_ch_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_re_q    <= '0;
         s2_im_q    <= '0;
         s2_ch_q    <= '0;
         ptr_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_re_q    <= s1_re_d;
         s1_im_q    <= s1_im_d;
         s1_cos_q   <= s1_cos_d;
         s1_sin_q   <= s1_sin_d;
         s1_ch_q    <= s1_ch_d;
         s2_valid_q <= s2_valid_d;
         s2_re_q    <= s2_re_d;
         s2_im_q    <= s2_im_d;
         s2_ch_q    <= s2_ch_d;
         ptr_q      <= ptr_d;
      end
   end

   assign mix_re_o    = s1_re_q;
   assign mix_im_o    = s1_im_q;
   assign mix_cos_o   = s1_cos_q;
   assign mix_sin_o   = s1_sin_q;
   assign out_valid_o = s2_valid_q;
   assign out_re_o    = s2_re_q;
   assign out_im_o    = s2_im_q;
   assign out_ch_o    = s2_ch_q;

`ifdef MIX_SCHED_STATS_EN
   logic [NUM_CH*STAT_W-1:0] stat_cnt_q, stat_cnt_d;

   // Saturating per-channel accept counters; clear wins over a same-cycle accept.
   always_comb begin
      stat_cnt_d = stat_cnt_q;
      if (stat_clr_i) begin
         stat_cnt_d = '0;
      end else if (any_gnt && (stat_cnt_q[gnt_idx*STAT_W +: STAT_W] != '1)) begin
         stat_cnt_d[gnt_idx*STAT_W +: STAT_W] = stat_cnt_q[gnt_idx*STAT_W +: STAT_W] + STAT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) stat_cnt_q <= '0;
      else       stat_cnt_q <= stat_cnt_d;
   end

   assign stat_cnt_o = stat_cnt_q;
`endif

endmodule

// File: tb/tb_mix_sched.sv
// Directed bench for mix_sched with a stub mixer: (re*cos-im*sin)>>>15, (re*sin+im*cos)>>>15.
// Latency: checks the 2-cycle accept-to-output path and round-robin order.
// Backpressure: exercises stall, enable drop and asynchronous reset.
module tb_mix_sched;
   import mix_sched_pkg::*;

   localparam int NUM_CH = 4;
   localparam int IO_W   = 16;
   localparam int CH_W   = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   enable;
   logic [NUM_CH-1:0]      req_valid;
   logic [NUM_CH-1:0]      req_ready;
   logic [NUM_CH*IO_W-1:0] req_re, req_im, req_cos, req_sin;
   logic [IO_W-1:0]        mix_re_o, mix_im_o, mix_cos_o, mix_sin_o;
   logic [IO_W-1:0]        mix_re_i, mix_im_i;
   logic                   out_valid;
   logic                   out_ready;
   logic [IO_W-1:0]        out_re, out_im;
   logic [CH_W-1:0]        out_ch;
`ifdef MIX_SCHED_STATS_EN
   logic                   stat_clr;
   logic [NUM_CH*16-1:0]   stat_cnt;
`endif

   iq_sample_t iq [NUM_CH];
   lo_sample_t lo [NUM_CH];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mix_sched #(.NUM_CH(NUM_CH), .IO_W(IO_W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .enable_i    (enable),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_re_i    (req_re),
      .req_im_i    (req_im),
      .req_cos_i   (req_cos),
      .req_sin_i   (req_sin),
      .mix_re_o    (mix_re_o),
      .mix_im_o    (mix_im_o),
      .mix_cos_o   (mix_cos_o),
      .mix_sin_o   (mix_sin_o),
      .mix_re_i    (mix_re_i),
      .mix_im_i    (mix_im_i),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_re_o    (out_re),
      .out_im_o    (out_im),
      .out_ch_o    (out_ch)
`ifdef MIX_SCHED_STATS_EN
      ,
      .stat_clr_i  (stat_clr),
      .stat_cnt_o  (stat_cnt)
`endif
   );

   // Stub Q15 complex mixer.
   logic signed [31:0] prod_re, prod_im;
   assign prod_re  = $signed(mix_re_o) * $signed(mix_cos_o) - $signed(mix_im_o) * $signed(mix_sin_o);
   assign prod_im  = $signed(mix_re_o) * $signed(mix_sin_o) + $signed(mix_im_o) * $signed(mix_cos_o);
   assign mix_re_i = 16'(prod_re >>> 15);
   assign mix_im_i = 16'(prod_im >>> 15);

   // Flatten per-channel sample tables onto the request buses.
   always_comb begin
      req_re  = '0;
      req_im  = '0;
      req_cos = '0;
      req_sin = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         req_re[k*IO_W +: IO_W]  = iq[k].re;
         req_im[k*IO_W +: IO_W]  = iq[k].im;
         req_cos[k*IO_W +: IO_W] = lo[k].cos;
         req_sin[k*IO_W +: IO_W] = lo[k].sin;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to the next sample point, 2 time units after the falling edge.
   task automatic step();
      @(negedge clk);
      #2;
   endtask

   // Channel k: re=0x1000*(k+1), im=0x0800*(k+1), cos=0x7FFF, sin=0.
   // Through the stub mixer: out_re = re-1, out_im = im-1.
   task automatic load_data();
      for (int k = 0; k < NUM_CH; k++) begin
         iq[k].re  = 16'(32'h1000 * (k + 1));
         iq[k].im  = 16'(32'h0800 * (k + 1));
         lo[k].cos = 16'h7FFF;
         lo[k].sin = 16'h0000;
      end
   endtask

   function automatic logic [31:0] exp_re(input int k);
      return 32'(16'(32'h1000 * (k + 1) - 1));
   endfunction

   function automatic logic [31:0] exp_im(input int k);
      return 32'(16'(32'h0800 * (k + 1) - 1));
   endfunction

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      enable    = 1'b0;
      out_ready = 1'b1;
`ifdef MIX_SCHED_STATS_EN
      stat_clr  = 1'b0;
`endif
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      enable    = 1'b1;
      out_ready = 1'b1;
      req_valid = '1;
`ifdef MIX_SCHED_STATS_EN
      stat_clr  = 1'b0;
`endif
      load_data();
      step();
      // Reset state, with requests pending and enable high.
      chk("rst_rdy",    32'(req_ready), 32'h0);
      chk("rst_vld",    32'(out_valid), 32'h0);
      chk("rst_out_re", 32'(out_re),    32'h0);
      chk("rst_out_ch", 32'(out_ch),    32'h0);
      chk("rst_mix_re", 32'(mix_re_o),  32'h0);

      // Test 1: all channels valid, full throughput, round-robin order.
      do_reset();
      load_data();
      req_valid = '1; enable = 1'b1; out_ready = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         chk("t1_rdy", 32'(req_ready), 32'(1 << (i % 4)));
         if (i == 1) chk("t1_mix_re", 32'(mix_re_o), 32'h1000);
         if (i >= 2) begin
            chk("t1_vld",    32'(out_valid), 32'h1);
            chk("t1_out_ch", 32'(out_ch),    32'((i - 2) % 4));
            chk("t1_out_re", 32'(out_re),    exp_re((i - 2) % 4));
            chk("t1_out_im", 32'(out_im),    exp_im((i - 2) % 4));
         end else begin
            chk("t1_vld_lat", 32'(out_valid), 32'h0);
         end
         step();
      end

      // Test 2: single channel 2, Q15 unity LO.
      do_reset();
      load_data();
      iq[2].re = 16'h1000; iq[2].im = 16'h0000;
      lo[2].cos = 16'h7FFF; lo[2].sin = 16'h0000;
      req_valid = 4'b0100; enable = 1'b1;
      #1;
      chk("t2_rdy", 32'(req_ready), 32'h4);
      step();
      req_valid = '0;
      #1;
      chk("t2_mix_re",  32'(mix_re_o),  32'h1000);
      chk("t2_mix_cos", 32'(mix_cos_o), 32'h7FFF);
      chk("t2_vld_lat", 32'(out_valid), 32'h0);
      chk("t2_rdy_off", 32'(req_ready), 32'h0);
      step();
      chk("t2_vld",    32'(out_valid), 32'h1);
      chk("t2_out_re", 32'(out_re),    32'h0FFF);
      chk("t2_out_im", 32'(out_im),    32'h0000);
      chk("t2_out_ch", 32'(out_ch),    32'h2);
      step();
      chk("t2_vld_end", 32'(out_valid), 32'h0);

      // Test 3: downstream stall for 5 cycles with all channels valid.
      do_reset();
      load_data();
      req_valid = '1; enable = 1'b1; out_ready = 1'b0;
      #1;
      chk("t3_rdy0", 32'(req_ready), 32'h1);
      step();
      chk("t3_rdy1", 32'(req_ready), 32'h2);
      step();
      for (int j = 2; j < 5; j++) begin
         chk("t3_stall_rdy",    32'(req_ready), 32'h0);
         chk("t3_stall_vld",    32'(out_valid), 32'h1);
         chk("t3_stall_ch",     32'(out_ch),    32'h0);
         chk("t3_stall_out_re", 32'(out_re),    exp_re(0));
         chk("t3_stall_mix_re", 32'(mix_re_o),  32'h2000);
         if (j < 4) step();
      end
      out_ready = 1'b1;
      #1;
      chk("t3_resume_rdy", 32'(req_ready), 32'h4);
      step();
      for (int j = 0; j < 4; j++) begin
         chk("t3_drain_ch", 32'(out_ch), 32'((j + 1) % 4));
         chk("t3_drain_re", 32'(out_re), exp_re((j + 1) % 4));
         step();
      end

      // Test 4: enable dropped with both stages full.
      do_reset();
      load_data();
      req_valid = '1; enable = 1'b1; out_ready = 1'b0;
      #1;
      step();
      step();
      enable = 1'b0; out_ready = 1'b1;
      #1;
      chk("t4_rdy_a", 32'(req_ready), 32'h0);
      chk("t4_vld_a", 32'(out_valid), 32'h1);
      chk("t4_ch_a",  32'(out_ch),    32'h0);
      step();
      chk("t4_rdy_b", 32'(req_ready), 32'h0);
      chk("t4_vld_b", 32'(out_valid), 32'h1);
      chk("t4_ch_b",  32'(out_ch),    32'h1);
      step();
      chk("t4_rdy_c", 32'(req_ready), 32'h0);
      chk("t4_vld_c", 32'(out_valid), 32'h0);
      step();
      chk("t4_vld_d", 32'(out_valid), 32'h0);
      enable = 1'b1;
      #1;
      chk("t4_resume_rdy", 32'(req_ready), 32'h4);
      step();
      chk("t4_resume_mix", 32'(mix_re_o), 32'h3000);

      // Test 5: asynchronous reset mid-stream.
      do_reset();
      load_data();
      req_valid = '1; enable = 1'b1; out_ready = 1'b1;
      #1;
      step();
      step();
      step();
      chk("t5_pre_vld", 32'(out_valid), 32'h1);
      rst = 1'b1;
      #1;
      chk("t5_vld",    32'(out_valid), 32'h0);
      chk("t5_out_re", 32'(out_re),    32'h0);
      chk("t5_out_ch", 32'(out_ch),    32'h0);
      chk("t5_mix_re", 32'(mix_re_o),  32'h0);
      chk("t5_rdy",    32'(req_ready), 32'h0);
      step();
      rst = 1'b0;
      #1;
      chk("t5_first_rdy", 32'(req_ready), 32'h1);
      step();
      chk("t5_first_mix", 32'(mix_re_o),  32'h1000);
      chk("t5_no_stale",  32'(out_valid), 32'h0);
      step();
      chk("t5_first_out", 32'(out_ch),    32'h0);

`ifdef MIX_SCHED_STATS_EN
      // Statistics: saturation after 70000 ch1 accepts, clear beats same-cycle accept.
      do_reset();
      load_data();
      req_valid = 4'b0010; enable = 1'b1; out_ready = 1'b1;
      #1;
      repeat (70000) step();
      chk("st_sat_ch1", 32'(stat_cnt[31:16]), 32'hFFFF);
      chk("st_ch0",     32'(stat_cnt[15:0]),  32'h0);
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      chk("st_clr_ch1", 32'(stat_cnt[31:16]), 32'h0);
      step();
      chk("st_inc_ch1", 32'(stat_cnt[31:16]), 32'h1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
